rob_multiport: RTL and testbench
================================

Name: rob_multiport

Overview:
- Parametrised next-generation reorder buffer. Dispatch, commit and completion widths are independent parameters, and depth need not be a power of two.
- Adds per-lane dispatch backpressure, at most one store committed per cycle, a redirect PC on squash, and a sticky halt state.
- Sits between dispatch/rename (write side), the CDB/functional units (completion side), and retire/arch-map/store-queue (commit side).

Parameters:
- SIZE, 32, number of entries (any value >= 2)
- DISPATCH_W, 2, dispatch lanes per cycle
- COMMIT_W, 2, commit lanes per cycle
- CDB_W, 3, completion ports per cycle

Ports:
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- dispatch_valid  in  DISPATCH_W  lane valid; set lanes are contiguous from lane 0
- dispatch_entry  in  DISPATCH_W x ROBM_ENTRY  new entries (executed=0, mispredict=0 on entry)
- dispatch_ready  out  DISPATCH_W  lane i may be accepted this cycle
- dispatch_robn  out  DISPATCH_W x ROBM_PTR  index lane i will occupy
- cdb_valid  in  CDB_W  completion valid
- cdb_robn  in  CDB_W x ROBM_PTR  completing entry
- cdb_taken  in  CDB_W  resolved branch direction
- cdb_target  in  CDB_W x ADDR  resolved branch target
- commit_valid  out  COMMIT_W  lane retires this cycle
- commit_entry  out  COMMIT_W x ROBM_ENTRY  retiring entries, oldest in lane 0
- squash  out  1  flush the pipeline this cycle
- squash_pc  out  ADDR  redirect address
- free_slots  out  clog2(SIZE+1)  equals SIZE - count
- halted  out  1  halt has retired

Behaviour:
- State:
  - head and tail are clog2(SIZE) bits; count is clog2(SIZE+1) bits.
  - Wrap is explicit: when ptr == SIZE-1, the next value is 0. Modulo is not used.
- Reset:
  - head=tail=count=0, halted=0, all entries cleared.
  - While reset is high: commit_valid=0, squash=0, squash_pc=0, dispatch_ready=0.
  - After reset: free_slots=SIZE.
- Dispatch:
  - dispatch_ready[i] = (i < free_slots) && !halted && !squash. free_slots is the start-of-cycle value; slots freed by commit are not reused in the same cycle.
  - dispatch_robn[i] = tail+i with wrap.
  - Accepted lanes write at the next edge. tail and count advance by the number accepted.
- Completion:
  - A valid CDB port sets executed=1, resolve_taken and resolve_target.
  - If the entry is a branch, mispredict = (taken != predict_taken) || (taken && target != predict_target).
  - Writes become visible to commit the next cycle (zero bypass).
  - Duplicate robn across ports, and CDB to an entry dispatched in the same cycle, are illegal and flagged by a bench assertion.
- Commit: scan lanes k = 0..COMMIT_W-1 from head and stop at the first lane where any of these holds:
  - k >= count
  - entry not executed
  - entry is a store and an earlier lane this cycle already committed a store
  - halted, or an earlier lane committed a halt or a mispredict
- Mispredict lane:
  - The mispredicted branch itself commits, with commit_valid=1.
  - In the same cycle, combinationally: squash=1 and squash_pc = resolve_taken ? resolve_target : NPC.
  - Next edge: head=tail=count=0. Dispatch and CDB writes in the squash cycle are discarded.
- Halt entry: it commits, halted is set next edge, and halted stays set until reset.
- Simultaneous events:
  - Commit and dispatch in the same cycle: count_next = count - commits + accepts.
  - Full (count=SIZE): all dispatch_ready=0.
  - Empty: commit_valid=0.
- Latency: dispatch to earliest commit is 2 cycles (dispatch edge, CDB edge, commit combinational).

Optional Feature:
- ROBM_PERF_CNT_EN
- With the macro defined:
  - Adds 32-bit outputs perf_commits, perf_squashes and perf_full_cycles.
  - Counters are cleared by reset, saturate at all-ones, and increment by commits per cycle, squash cycles, and cycles with count=SIZE respectively.
- Without the macro: these ports and counters do not exist, and functional behaviour is identical.

Decomposition:
- Shared package contents:
  - ROBM_ENTRY struct: executed, mispredict, is_store, is_branch, predict_taken, predict_target, resolve_taken, resolve_target, dest_prn, dest_arn, PC, NPC, halt, illegal, csr_op.
  - ROBM_PTR typedef.
  - ROBM_ENTRY_RESET constant.
- One natural sub-module: rob_commit_select. It is combinational and takes the head window of COMMIT_W entries, count and halted. It returns commit_valid, the commit count, squash and squash_pc.

Test Plan:
- Directed scenarios with SIZE=8, DISPATCH_W=2, COMMIT_W=2.
- Reset, then 4 cycles dispatching 2 per cycle -> free_slots 8,6,4,2,0. At count=8, dispatch_ready=00 and dispatch_robn=0,1 after wrap.
- Fill, complete robn 1 then robn 0 -> no commit until robn 0 executes, then both commit in one cycle in lanes 0,1.
- Head two executed stores -> one commit per cycle, over 2 cycles.
- Branch at head, predict_taken=0, CDB taken=1 target=0x40 -> commit_valid=01, squash=1, squash_pc=0x40. Next cycle free_slots=8 and a same-cycle dispatch is dropped.
- Halt at lane 0 with an executed entry behind it -> only lane 0 commits, halted=1 thereafter, dispatch_ready=0 until reset.
- Assert reset mid-stream with count=5 -> next cycle free_slots=8, commit_valid=0, squash=0. With ROBM_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/rob_multiport_pkg.sv
// Shared types for the multi-port reorder buffer: entry record, robn pointer type, reset constant.
// The optional ROBM_PERF_CNT_EN macro (see rob_multiport.sv) does not affect this package.
package rob_multiport_pkg;

    localparam int ROBM_ADDR_W = 32;
    // Wide enough for any SIZE up to 256; the buffer uses only the low clog2(SIZE) bits.
    localparam int ROBM_PTR_W  = 8;

    typedef logic [ROBM_PTR_W-1:0] ROBM_PTR;

    typedef struct packed {
        logic                   executed;
        logic                   mispredict;
        logic                   is_store;
        logic                   is_branch;
        logic                   predict_taken;
        logic [ROBM_ADDR_W-1:0] predict_target;
        logic                   resolve_taken;
        logic [ROBM_ADDR_W-1:0] resolve_target;
        logic [6:0]             dest_prn;
        logic [4:0]             dest_arn;
        logic [ROBM_ADDR_W-1:0] pc;
        logic [ROBM_ADDR_W-1:0] npc;
        logic                   halt;
        logic                   illegal;
        logic                   csr_op;
    } ROBM_ENTRY;

    localparam ROBM_ENTRY ROBM_ENTRY_RESET = '0;

endpackage

// File: rtl/rob_multiport_commit_select.sv
// Combinational in-order retire selection over the COMMIT_W-entry head window.
// Stops at the first blocked lane; a mispredicting lane retires and raises squash.
module rob_commit_select
    import rob_multiport_pkg::*;
#(
    parameter int COMMIT_W = 2,
    parameter int CNT_W    = 6,
    parameter int CCNT_W   = 2
) (
    input  ROBM_ENTRY [COMMIT_W-1:0] window,
    input  logic [CNT_W-1:0]         count,
    input  logic                     halted,
    output logic [COMMIT_W-1:0]      commit_valid,
    output logic [CCNT_W-1:0]        commit_cnt,
    output logic                     squash,
    output logic [ROBM_ADDR_W-1:0]   squash_pc,
    output ROBM_ENTRY [COMMIT_W-1:0] commit_entry
);

    logic stop;
    logic store_seen;

    assign commit_entry = window;

    always_comb begin
        commit_valid = '0;
        commit_cnt   = '0;
        squash       = 1'b0;
        squash_pc    = '0;
        stop         = halted;
        store_seen   = 1'b0;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (!stop) begin
                if (k >= int'(count) || !window[k].executed ||
                    (window[k].is_store && store_seen)) begin
                    stop = 1'b1;
                end else begin
                    commit_valid[k] = 1'b1;
                    commit_cnt      = commit_cnt + CCNT_W'(1);
                    store_seen      = store_seen | window[k].is_store;
                    // Younger lanes never retire past a redirect or a halt.
                    if (window[k].mispredict) begin
                        squash    = 1'b1;
                        squash_pc = window[k].resolve_taken ? window[k].resolve_target
                                                            : window[k].npc;
                        stop      = 1'b1;
                    end else if (window[k].halt) begin
                        stop = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rob_multiport.sv
// Reorder buffer with independent dispatch/commit/CDB widths and non-power-of-two depth.
// Define ROBM_PERF_CNT_EN to add saturating commit/squash/full-cycle counters.
module rob_multiport
    import rob_multiport_pkg::*;
#(
    parameter int SIZE       = 32,
    parameter int DISPATCH_W = 2,
    parameter int COMMIT_W   = 2,
    parameter int CDB_W      = 3
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [DISPATCH_W-1:0]                dispatch_valid,
    input  ROBM_ENTRY [DISPATCH_W-1:0]           dispatch_entry,
    output logic [DISPATCH_W-1:0]                dispatch_ready,
    output ROBM_PTR [DISPATCH_W-1:0]             dispatch_robn,
    input  logic [CDB_W-1:0]                     cdb_valid,
    input  ROBM_PTR [CDB_W-1:0]                  cdb_robn,
    input  logic [CDB_W-1:0]                     cdb_taken,
    input  logic [CDB_W-1:0][ROBM_ADDR_W-1:0]    cdb_target,
    output logic [COMMIT_W-1:0]                  commit_valid,
    output ROBM_ENTRY [COMMIT_W-1:0]             commit_entry,
    output logic                                 squash,
    output logic [ROBM_ADDR_W-1:0]               squash_pc,
    output logic [$clog2(SIZE+1)-1:0]            free_slots,
    output logic                                 halted
`ifdef ROBM_PERF_CNT_EN
    ,
    output logic [31:0]                          perf_commits,
    output logic [31:0]                          perf_squashes,
    output logic [31:0]                          perf_full_cycles
`endif
);

    localparam int PTR_W  = $clog2(SIZE);
    localparam int CNT_W  = $clog2(SIZE + 1);
    localparam int CCNT_W = $clog2(COMMIT_W + 1);
    localparam int ACNT_W = $clog2(DISPATCH_W + 1);

    ROBM_ENTRY              entries [SIZE];
    logic [PTR_W-1:0]       head, tail;
    logic [CNT_W-1:0]       count;
    logic                   halted_q;

    ROBM_ENTRY [COMMIT_W-1:0]   window;
    ROBM_ENTRY [DISPATCH_W-1:0] disp_wr;
    logic [PTR_W-1:0]       disp_idx [DISPATCH_W];
    logic [PTR_W-1:0]       cdb_idx  [CDB_W];
    logic [CDB_W-1:0]       cdb_mis;
    logic [COMMIT_W-1:0]    sel_valid;
    logic [CCNT_W-1:0]      sel_cnt;
    logic                   sel_squash;
    logic [ROBM_ADDR_W-1:0] sel_pc;
    logic                   commit_halt;
    logic [ACNT_W-1:0]      accept_n;

    // Pointer advance with explicit wrap; n is never larger than SIZE.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= SIZE) s = s - SIZE;
        return PTR_W'(s);
    endfunction

    always_comb begin
        for (int k = 0; k < COMMIT_W; k++) begin
            window[k] = entries[ptr_add(head, k)];
        end
    end

    rob_commit_select #(
        .COMMIT_W (COMMIT_W),
        .CNT_W    (CNT_W),
        .CCNT_W   (CCNT_W)
    ) u_commit_select (
        .window       (window),
        .count        (count),
        .halted       (halted_q),
        .commit_valid (sel_valid),
        .commit_cnt   (sel_cnt),
        .squash       (sel_squash),
        .squash_pc    (sel_pc),
        .commit_entry (commit_entry)
    );

    assign free_slots   = CNT_W'(SIZE) - count;
    assign halted       = halted_q;
    assign commit_valid = reset ? '0 : sel_valid;
    assign squash       = !reset && sel_squash;
    assign squash_pc    = squash ? sel_pc : '0;

    always_comb begin
        commit_halt = 1'b0;
        for (int k = 0; k < COMMIT_W; k++) begin
            commit_halt = commit_halt | (sel_valid[k] && window[k].halt);
        end
    end

    always_comb begin
        accept_n = '0;
        for (int i = 0; i < DISPATCH_W; i++) begin
            disp_idx[i]          = ptr_add(tail, i);
            dispatch_robn[i]     = ROBM_PTR'(disp_idx[i]);
            dispatch_ready[i]    = !reset && (i < int'(free_slots)) && !halted_q && !sel_squash;
            disp_wr[i]           = dispatch_entry[i];
            disp_wr[i].executed   = 1'b0;
            disp_wr[i].mispredict = 1'b0;
            if (dispatch_valid[i] && dispatch_ready[i]) accept_n = accept_n + ACNT_W'(1);
        end
    end

    always_comb begin
        for (int j = 0; j < CDB_W; j++) begin
            cdb_idx[j] = PTR_W'(cdb_robn[j]);
            cdb_mis[j] = entries[cdb_idx[j]].is_branch &&
                         ((cdb_taken[j] != entries[cdb_idx[j]].predict_taken) ||
                          (cdb_taken[j] && cdb_target[j] != entries[cdb_idx[j]].predict_target));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            halted_q <= 1'b0;
            for (int e = 0; e < SIZE; e++) entries[e] <= ROBM_ENTRY_RESET;
        end else if (sel_squash) begin
            // Everything younger than the retiring branch is discarded.
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            halted_q <= halted_q | commit_halt;
        end else begin
            for (int i = 0; i < DISPATCH_W; i++) begin
                if (dispatch_valid[i] && dispatch_ready[i]) entries[disp_idx[i]] <= disp_wr[i];
            end
            for (int j = 0; j < CDB_W; j++) begin
                if (cdb_valid[j]) begin
                    entries[cdb_idx[j]].executed       <= 1'b1;
                    entries[cdb_idx[j]].resolve_taken  <= cdb_taken[j];
                    entries[cdb_idx[j]].resolve_target <= cdb_target[j];
                    entries[cdb_idx[j]].mispredict     <= cdb_mis[j];
                end
            end
            head     <= ptr_add(head, int'(sel_cnt));
            tail     <= ptr_add(tail, int'(accept_n));
            count    <= count - CNT_W'(sel_cnt) + CNT_W'(accept_n);
            halted_q <= halted_q | commit_halt;
        end
    end

`ifdef ROBM_PERF_CNT_EN
    logic [32:0] commits_sum;
    assign commits_sum = {1'b0, perf_commits} + 33'(sel_cnt);

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_commits     <= '0;
            perf_squashes    <= '0;
            perf_full_cycles <= '0;
        end else begin
            perf_commits <= commits_sum[32] ? '1 : commits_sum[31:0];
            if (sel_squash && perf_squashes != '1) perf_squashes <= perf_squashes + 32'd1;
            if (count == CNT_W'(SIZE) && perf_full_cycles != '1)
                perf_full_cycles <= perf_full_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rob_multiport.sv
// Directed, table-driven bench for rob_multiport at SIZE=8, two dispatch and two commit lanes.
module tb_rob_multiport;
    import rob_multiport_pkg::*;

    localparam int SIZE = 8;
    localparam int DW   = 2;
    localparam int CW   = 2;
    localparam int BW   = 3;

    logic                            clock = 1'b0;
    logic                            reset;
    logic [DW-1:0]                   dispatch_valid;
    ROBM_ENTRY [DW-1:0]              dispatch_entry;
    logic [DW-1:0]                   dispatch_ready;
    ROBM_PTR [DW-1:0]                dispatch_robn;
    logic [BW-1:0]                   cdb_valid;
    ROBM_PTR [BW-1:0]                cdb_robn;
    logic [BW-1:0]                   cdb_taken;
    logic [BW-1:0][ROBM_ADDR_W-1:0]  cdb_target;
    logic [CW-1:0]                   commit_valid;
    ROBM_ENTRY [CW-1:0]              commit_entry;
    logic                            squash;
    logic [ROBM_ADDR_W-1:0]          squash_pc;
    logic [3:0]                      free_slots;
    logic                            halted;
`ifdef ROBM_PERF_CNT_EN
    logic [31:0]                     perf_commits, perf_squashes, perf_full_cycles;
`endif

    rob_multiport #(.SIZE(SIZE), .DISPATCH_W(DW), .COMMIT_W(CW), .CDB_W(BW)) dut (
        .clock          (clock),
        .reset          (reset),
        .dispatch_valid (dispatch_valid),
        .dispatch_entry (dispatch_entry),
        .dispatch_ready (dispatch_ready),
        .dispatch_robn  (dispatch_robn),
        .cdb_valid      (cdb_valid),
        .cdb_robn       (cdb_robn),
        .cdb_taken      (cdb_taken),
        .cdb_target     (cdb_target),
        .commit_valid   (commit_valid),
        .commit_entry   (commit_entry),
        .squash         (squash),
        .squash_pc      (squash_pc),
        .free_slots     (free_slots),
        .halted         (halted)
`ifdef ROBM_PERF_CNT_EN
        ,
        .perf_commits     (perf_commits),
        .perf_squashes    (perf_squashes),
        .perf_full_cycles (perf_full_cycles)
`endif
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // CDB stimulus legality: no duplicate robn, no completion of a same-cycle dispatch
    always @(posedge clock) begin
        if (!reset) begin
            for (int a = 0; a < BW; a++) begin
                for (int b = a + 1; b < BW; b++)
                    assert (!(cdb_valid[a] && cdb_valid[b] && cdb_robn[a] == cdb_robn[b]))
                        else $error("illegal duplicate CDB robn %0d", cdb_robn[a]);
                for (int d = 0; d < DW; d++)
                    assert (!(cdb_valid[a] && dispatch_valid[d] && dispatch_ready[d] &&
                              cdb_robn[a] == dispatch_robn[d]))
                        else $error("CDB to entry dispatched this cycle %0d", cdb_robn[a]);
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // driver tasks
    function automatic ROBM_ENTRY mk(input logic st, input logic br, input logic pt,
                                     input logic hl, input logic [31:0] pc,
                                     input logic [31:0] ptgt);
        ROBM_ENTRY e;
        e                = ROBM_ENTRY_RESET;
        e.is_store       = st;
        e.is_branch      = br;
        e.predict_taken  = pt;
        e.predict_target = ptgt;
        e.halt           = hl;
        e.pc             = pc;
        e.npc            = pc + 32'd4;
        e.dest_arn       = pc[6:2];
        e.executed       = 1'b1;  // must be ignored on dispatch
        return e;
    endfunction

    task automatic drive_disp(input logic [1:0] v, input ROBM_ENTRY e0, input ROBM_ENTRY e1);
        dispatch_valid    = v;
        dispatch_entry[0] = e0;
        dispatch_entry[1] = e1;
    endtask

    task automatic drive_cdb(input int port, input int robn, input logic tk, input logic [31:0] tgt);
        cdb_valid[port]  = 1'b1;
        cdb_robn[port]   = ROBM_PTR'(robn);
        cdb_taken[port]  = tk;
        cdb_target[port] = tgt;
    endtask

    task automatic next();
        @(posedge clock);
        #1;
        dispatch_valid = '0;
        cdb_valid      = '0;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        dispatch_valid = '0;
        cdb_valid      = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [1:0] dv;
        logic [3:0] exp_free;
        logic [1:0] exp_ready;
        logic [7:0] exp_robn0;
        logic [7:0] exp_robn1;
        logic [1:0] exp_commit;
    } fill_vec_t;

    typedef struct {
        logic        pt;
        logic [31:0] ptgt;
        logic        tk;
        logic [31:0] tgt;
        logic        exp_sq;
        logic [31:0] exp_pc;
    } br_vec_t;

    fill_vec_t fill_vecs [5];
    br_vec_t   br_vecs   [5];
    ROBM_ENTRY alu;

    initial begin
        fill_vecs[0] = '{2'b11, 4'd8, 2'b11, 8'd0, 8'd1, 2'b00};
        fill_vecs[1] = '{2'b11, 4'd6, 2'b11, 8'd2, 8'd3, 2'b00};
        fill_vecs[2] = '{2'b11, 4'd4, 2'b11, 8'd4, 8'd5, 2'b00};
        fill_vecs[3] = '{2'b11, 4'd2, 2'b11, 8'd6, 8'd7, 2'b00};
        fill_vecs[4] = '{2'b11, 4'd0, 2'b00, 8'd0, 8'd1, 2'b00};

        // branch pc = 0x200 + 0x10*i, npc = pc + 4
        br_vecs[0] = '{1'b0, 32'h0,  1'b1, 32'h40, 1'b1, 32'h40};
        br_vecs[1] = '{1'b1, 32'h80, 1'b0, 32'h0,  1'b1, 32'h214};
        br_vecs[2] = '{1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h0};
        br_vecs[3] = '{1'b1, 32'h80, 1'b1, 32'h90, 1'b1, 32'h90};
        br_vecs[4] = '{1'b0, 32'h80, 1'b0, 32'h55, 1'b0, 32'h0};

        alu            = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        dispatch_valid = '0;
        dispatch_entry = '0;
        cdb_valid      = '0;
        cdb_robn       = '0;
        cdb_taken      = '0;
        cdb_target     = '0;

        // Reset values while reset is held
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("rst ready",     64'(dispatch_ready), 64'(2'b00));
        check("rst commit",    64'(commit_valid),   64'(2'b00));
        check("rst squash",    64'(squash),         64'(1'b0));
        check("rst squash_pc", 64'(squash_pc),      64'(32'h0));
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Fill 2 per cycle until full; tail wraps back to 0
        for (int i = 0; i < 5; i++) begin
            drive_disp(fill_vecs[i].dv,
                       mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h100 + 32'(8 * i), 32'h0),
                       mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h104 + 32'(8 * i), 32'h0));
            @(negedge clock);
            check($sformatf("fill%0d free", i),   64'(free_slots),       64'(fill_vecs[i].exp_free));
            check($sformatf("fill%0d ready", i),  64'(dispatch_ready),   64'(fill_vecs[i].exp_ready));
            check($sformatf("fill%0d robn0", i),  64'(dispatch_robn[0]), 64'(fill_vecs[i].exp_robn0));
            check($sformatf("fill%0d robn1", i),  64'(dispatch_robn[1]), 64'(fill_vecs[i].exp_robn1));
            check($sformatf("fill%0d commit", i), 64'(commit_valid),     64'(fill_vecs[i].exp_commit));
            next();
        end

        // Out-of-order completion: robn 1 then robn 0, both retire together
        drive_cdb(0, 1, 1'b0, 32'h0);
        @(negedge clock);
        check("ooo wait0 commit", 64'(commit_valid), 64'(2'b00));
        next();
        @(negedge clock);
        check("ooo wait1 commit", 64'(commit_valid), 64'(2'b00));
        next();
        drive_cdb(2, 0, 1'b0, 32'h0);
        @(negedge clock);
        check("ooo wait2 commit", 64'(commit_valid), 64'(2'b00));
        next();
        @(negedge clock);
        check("ooo commit",       64'(commit_valid),       64'(2'b11));
        check("ooo lane0 pc",     64'(commit_entry[0].pc), 64'(32'h100));
        check("ooo lane1 pc",     64'(commit_entry[1].pc), 64'(32'h104));
        check("ooo free before",  64'(free_slots),         64'(4'd0));
        next();
        @(negedge clock);
        check("ooo free after",   64'(free_slots),         64'(4'd2));
        check("ooo commit after", 64'(commit_valid),       64'(2'b00));
        check("ooo ready after",  64'(dispatch_ready),     64'(2'b11));
        next();

        // Two executed stores: one per cycle; dispatch alongside the first commit
        do_reset();
        drive_disp(2'b11, mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0),
                          mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h304, 32'h0));
        next();
        drive_cdb(0, 0, 1'b0, 32'h0);
        drive_cdb(1, 1, 1'b0, 32'h0);
        next();
        drive_disp(2'b11, alu, alu);
        @(negedge clock);
        check("st1 commit", 64'(commit_valid),       64'(2'b01));
        check("st1 pc",     64'(commit_entry[0].pc), 64'(32'h300));
        check("st1 ready",  64'(dispatch_ready),     64'(2'b11));
        next();
        @(negedge clock);
        check("st2 commit", 64'(commit_valid),       64'(2'b01));
        check("st2 pc",     64'(commit_entry[0].pc), 64'(32'h304));
        check("st2 free",   64'(free_slots),         64'(4'd5));
        next();
        @(negedge clock);
        check("st3 commit", 64'(commit_valid),       64'(2'b00));
        check("st3 free",   64'(free_slots),         64'(4'd6));
        next();

        // Branch resolution table: lane 0 branch, lane 1 executed ALU op
        for (int i = 0; i < 5; i++) begin
            do_reset();
            drive_disp(2'b01, mk(1'b0, 1'b1, br_vecs[i].pt, 1'b0, 32'h200 + 32'(16 * i),
                                 br_vecs[i].ptgt), alu);
            dispatch_valid = 2'b11;
            next();
            drive_cdb(0, 0, br_vecs[i].tk, br_vecs[i].tgt);
            drive_cdb(1, 1, 1'b0, 32'h0);
            next();
            drive_disp(2'b11, alu, alu);
            @(negedge clock);
            check($sformatf("br%0d commit", i), 64'(commit_valid),
                  64'(br_vecs[i].exp_sq ? 2'b01 : 2'b11));
            check($sformatf("br%0d squash", i), 64'(squash),         64'(br_vecs[i].exp_sq));
            check($sformatf("br%0d pc", i),     64'(squash_pc),      64'(br_vecs[i].exp_pc));
            check($sformatf("br%0d ready", i),  64'(dispatch_ready),
                  64'(br_vecs[i].exp_sq ? 2'b00 : 2'b11));
            next();
            @(negedge clock);
            check($sformatf("br%0d free", i),   64'(free_slots),
                  64'(br_vecs[i].exp_sq ? 4'd8 : 4'd6));
            check($sformatf("br%0d squash after", i), 64'(squash), 64'(1'b0));
            next();
        end

        // Halt in lane 0 with an executed op behind it
        do_reset();
        drive_disp(2'b11, mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h700, 32'h0), alu);
        next();
        drive_cdb(0, 0, 1'b0, 32'h0);
        drive_cdb(1, 1, 1'b0, 32'h0);
        next();
        @(negedge clock);
        check("halt commit",      64'(commit_valid),         64'(2'b01));
        check("halt lane0 halt",  64'(commit_entry[0].halt), 64'(1'b1));
        check("halt not yet",     64'(halted),               64'(1'b0));
        next();
        drive_disp(2'b11, alu, alu);
        @(negedge clock);
        check("halted set",       64'(halted),         64'(1'b1));
        check("halted commit",    64'(commit_valid),   64'(2'b00));
        check("halted ready",     64'(dispatch_ready), 64'(2'b00));
        next();
        @(negedge clock);
        check("halted sticky",    64'(halted),         64'(1'b1));
        check("halted free",      64'(free_slots),     64'(4'd7));
        next();

        // Reset mid-stream at count=5
        do_reset();
        drive_disp(2'b11, alu, alu);
        next();
        drive_disp(2'b11, alu, alu);
        next();
        drive_disp(2'b01, alu, alu);
        next();
        @(negedge clock);
        check("mid free pre",    64'(free_slots), 64'(4'd3));
        check("mid halted pre",  64'(halted),     64'(1'b0));
        next();
        reset = 1'b1;
        drive_disp(2'b11, alu, alu);
        @(negedge clock);
        check("mid rst ready",   64'(dispatch_ready), 64'(2'b00));
        check("mid rst commit",  64'(commit_valid),   64'(2'b00));
        check("mid rst squash",  64'(squash),         64'(1'b0));
        @(posedge clock);
        #1;
        reset          = 1'b0;
        dispatch_valid = '0;
        @(negedge clock);
        check("mid free post",   64'(free_slots),   64'(4'd8));
        check("mid commit post", 64'(commit_valid), 64'(2'b00));
        check("mid squash post", 64'(squash),       64'(1'b0));
`ifdef ROBM_PERF_CNT_EN
        check("perf commits",    64'(perf_commits),     64'(0));
        check("perf squashes",   64'(perf_squashes),    64'(0));
        check("perf full",       64'(perf_full_cycles), 64'(0));
`endif
        next();

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
